// File: rtl/fifo_read_ctrl.sv
// Read-side drain controller: dequeues from the dual-clock FIFO into a 2-entry buffer
// and presents words on a valid/ready stream. Optional word counter under READ_CNT_EN.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_read,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  dequeue,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef READ_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t                state, state_nxt;
  logic [1:0]            occ;
  logic                  pend;
  logic [DATA_WIDTH-1:0] head, tail;
  logic                  pop;
  logic [2:0]            space;

  // occ + pend never exceeds 2, so space cannot underflow
  assign pop     = m_valid & m_ready;
  assign space   = 3'd2 - {1'b0, occ} - {2'b0, pend} + {2'b0, pop};
  assign dequeue = (state == RUN) & ~fifo_empty & (space != 3'd0);
  assign m_valid = (occ != 2'd0);
  assign m_data  = head;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = STOP;
      STOP: begin
        if (en)                          state_nxt = RUN;
        else if (!pend && occ == 2'd0)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage boundary: dequeue -> pend (FIFO read latency) -> capture into buffer
  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      pend <= dequeue;
      occ  <= occ + {1'b0, pend} - {1'b0, pop};
      if (pop) head <= tail;
      // Tail slot is the first free entry after this cycle's pop
      if (pend) begin
        if (occ == 2'd0 || (occ == 2'd1 && pop)) head <= fifo_data;
        else                                     tail <= fifo_data;
      end
    end
  end

`ifdef READ_CNT_EN
  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n)   rd_count <= '0;
    else if (pop) rd_count <= rd_count + CNT_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl: FIFO model feeds the DUT, a monitor pops expected
// words as the stream delivers them; directed tests check timing and boundaries.
module tb_fifo_read_ctrl;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, fifo_empty, dequeue, m_valid, m_ready, busy;
  logic [DW-1:0] fifo_data, m_data;
`ifdef READ_CNT_EN
  logic [CW-1:0] rd_count;
`endif

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          force_empty;
  int            checks = 0;
  int            errors = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  fifo_read_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_read  (clk),
    .rst_n     (rst_n),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .dequeue   (dequeue),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .busy      (busy)
`ifdef READ_CNT_EN
    ,
    .rd_count  (rd_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic upd_empty();
    fifo_empty = force_empty || (fifo_q.size() == 0);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    upd_empty();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    upd_empty();
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    check(name, exp_q.size(), 0);
  endtask

  // Reset discards buffered and in-flight words; only words still in the FIFO survive
  task automatic drop_lost();
    while (exp_q.size() > fifo_q.size()) void'(exp_q.pop_front());
  endtask

  // FIFO model: data_out valid the cycle after a dequeue
  always @(posedge clk) begin
    if (rst_n && dequeue && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
  end

  // Stream monitor
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst_n) begin
      if (fifo_empty) check("deq_while_empty", dequeue, 0);
      if (prev_hold) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", m_data, 'hFFFF);
        else begin
          e = exp_q.pop_front();
          check("stream_data", m_data, e);
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int deq_cnt, mv_cnt, last_pop, first_idle;
    logic [6:0] t1_deq;
    logic [6:0] t1_mv;
    t1_deq = 7'b0001110;
    t1_mv  = 7'b0111000;
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0; force_empty = 1'b0; fifo_data = '0;
    upd_empty();
    repeat (3) cyc();
    smp();
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_m_data", m_data, 0);
    check("rst_dequeue", dequeue, 0);
`ifdef READ_CNT_EN
    check("rst_rd_count", rd_count, 0);
`endif
    cyc();
    rst_n = 1'b1;

    // T1: three words, streaming at full rate
    cyc();
    en = 1'b1; m_ready = 1'b1;
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    for (int c = 0; c < 7; c++) begin
      smp();
      check($sformatf("t1_deq_c%0d", c), dequeue, t1_deq[c]);
      check($sformatf("t1_mv_c%0d", c), m_valid, t1_mv[c]);
      cyc();
    end
    en = 1'b0;
    repeat (3) cyc();
    smp();
    check("t1_idle_busy", busy, 0);

    // T2: consumer stalled, only two words leave the FIFO
    cyc();
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_word(8'hA0 + 8'(i));
    en = 1'b1;
    deq_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      smp();
      deq_cnt += int'(dequeue);
      cyc();
    end
    smp();
    check("t2_deq_count", deq_cnt, 2);
    check("t2_deq_held", dequeue, 0);
    check("t2_valid", m_valid, 1);
    check("t2_head", m_data, 8'hA1);
    cyc();
    m_ready = 1'b1;
    wait_drain(30, "t2_drain");
    en = 1'b0;
    repeat (3) cyc();

    // T3: en dropped right after a dequeue issued with one word buffered
    m_ready = 1'b0; en = 1'b1;
    push_word(8'hB1);
    cyc();
    smp();
    check("t3_deq_first", dequeue, 1);
    cyc(); cyc();
    push_word(8'hB2);
    smp();
    check("t3_deq_occ1", dequeue, 1);
    check("t3_valid_occ1", m_valid, 1);
    cyc();
    en = 1'b0;
    push_word(8'hB3);
    deq_cnt = 0; last_pop = -1; first_idle = -1;
    for (int c = 4; c < 12; c++) begin
      if (c == 6) m_ready = 1'b1;
      smp();
      deq_cnt += int'(dequeue);
      if (m_valid && m_ready) last_pop = c;
      if (!busy && first_idle < 0) first_idle = c;
      cyc();
    end
    check("t3_no_deq_stop", deq_cnt, 0);
    check("t3_last_pop", last_pop, 7);
    check("t3_busy_fall", first_idle, 9);
    check("t3_left_in_fifo", exp_q.size(), 1);

    // T4: FIFO reports empty throughout
    force_empty = 1'b1; en = 1'b1;
    upd_empty();
    deq_cnt = 0; mv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      smp();
      deq_cnt += int'(dequeue);
      mv_cnt  += int'(m_valid);
      cyc();
    end
    smp();
    check("t4_no_deq", deq_cnt, 0);
    check("t4_no_valid", mv_cnt, 0);
    check("t4_busy", busy, 1);
    cyc();
    force_empty = 1'b0;
    upd_empty();
    wait_drain(20, "t4_release_drain");

    // Empty flag toggling every cycle
    for (int i = 1; i <= 4; i++) push_word(8'hC0 + 8'(i));
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
      force_empty = ~force_empty;
      upd_empty();
    end
    check("toggle_drain", exp_q.size(), 0);
    force_empty = 1'b0; en = 1'b0;
    upd_empty();
    repeat (3) cyc();

    // T5: reset with a word buffered and one in flight
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push_word(8'hD0 + 8'(i));
    en = 1'b1;
    cyc(); cyc(); cyc();
    smp();
    check("t5_pre_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_deq", dequeue, 0);
    drop_lost();
`ifdef READ_CNT_EN
    check("t5_rst_count", rd_count, 0);
`endif
    cyc(); cyc();
    rst_n = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      smp();
      if (m_valid) break;
      cyc();
    end
    check("t5_resume_word", m_data, 8'hD3);
    cyc();
    wait_drain(30, "t5_drain");

    // T6: 17 pops wrap a 4-bit counter
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    drop_lost();
`ifdef READ_CNT_EN
    smp();
    check("t6_count_zero", rd_count, 0);
    cyc();
`endif
    for (int i = 0; i < 17; i++) push_word(8'hE0 + 8'(i));
    wait_drain(80, "t6_drain");
    repeat (2) cyc();
`ifdef READ_CNT_EN
    smp();
    check("t6_count_wrap", rd_count, 1);
`endif
    en = 1'b0;
    repeat (4) cyc();
    smp();
    check("final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
